// File: rtl/sump_pkg.sv
// Shared definitions for the SUMP command receiver: FSM state encoding,
// well-known opcode values and the long-command flag bit position.
package sump_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_STOP     = 3'd3,
        ST_WAITHIGH = 3'd4,
        ST_ANALYZE  = 3'd5
    } rx_state_t;

    // SUMP opcodes handled by the command decoder downstream
    localparam logic [7:0] OP_RESET = 8'h00;
    localparam logic [7:0] OP_RUN   = 8'h01;
    localparam logic [7:0] OP_ID    = 8'h02;
    localparam logic [7:0] OP_XON   = 8'h11;
    localparam logic [7:0] OP_XOFF  = 8'h13;

    // Opcode bit that marks a long (opcode + 4 data bytes) command
    localparam int LONG_CMD_BIT = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset
// to 1 so an idle-high serial line does not look like a start bit after reset.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Shift the asynchronous input through two flops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/receiver.sv
// UART 8N1 receiver and SUMP command assembler. Short commands (bit 7 clear)
// complete after one byte; long commands collect four data bytes, LSB first.
// Completed commands are presented on op/data with a one-cycle execute strobe.
// Optional feature: define RECEIVER_TIMEOUT_EN to drop a partial long command
// after TIMEOUT_BITS idle bit times.
module receiver
    import sump_pkg::*;
#(
    parameter int FREQ      = 100000000,
    parameter int BAUDRATE  = 115200,
    parameter int BITLENGTH = FREQ / BAUDRATE
`ifdef RECEIVER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_BITS = 40
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trxClock,
    input  logic        rx,
    output logic [7:0]  op,
    output logic [31:0] data,
    output logic        execute
);

    localparam logic [9:0] BIT_FULL = 10'(BITLENGTH);
    localparam logic [9:0] BIT_HALF = 10'(BITLENGTH / 2);

    logic       rx_s;

    rx_state_t   state_reg, state_next;
    logic [9:0]  count_reg, count_next;
    logic [2:0]  bit_index_reg, bit_index_next;
    logic [7:0]  shift_reg, shift_next;
    logic [2:0]  byte_count_reg, byte_count_next;
    logic [7:0]  opcode_reg, opcode_next;     // pending long-command opcode
    logic [23:0] data_buf_reg, data_buf_next; // lower three data lanes in flight
    logic [7:0]  op_reg, op_next;
    logic [31:0] data_reg, data_next;
    logic        execute_reg, execute_next;

    sync_2ff u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef RECEIVER_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_BITS * BITLENGTH);

    logic [31:0] timeout_reg, timeout_next;
    logic        timeout_hit;

    // Count idle baud ticks only while a long command is partially received
    always_comb begin
        timeout_next = 32'd0;
        if (state_reg == ST_IDLE && byte_count_reg != 3'd0) begin
            timeout_next = trxClock ? timeout_reg + 32'd1 : timeout_reg;
        end
    end

    assign timeout_hit = (timeout_reg >= TIMEOUT_LIMIT);

    // Timeout counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_reg <= 32'd0;
        end else begin
            timeout_reg <= timeout_next;
        end
    end
`endif

    // State, datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            count_reg      <= 10'd0;
            bit_index_reg  <= 3'd0;
            shift_reg      <= 8'h00;
            byte_count_reg <= 3'd0;
            opcode_reg     <= OP_RESET;
            data_buf_reg   <= 24'h000000;
            op_reg         <= OP_RESET;
            data_reg       <= 32'h00000000;
            execute_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            bit_index_reg  <= bit_index_next;
            shift_reg      <= shift_next;
            byte_count_reg <= byte_count_next;
            opcode_reg     <= opcode_next;
            data_buf_reg   <= data_buf_next;
            op_reg         <= op_next;
            data_reg       <= data_next;
            execute_reg    <= execute_next;
        end
    end

    // Next-state logic: bit framing, byte assembly and command completion
    always_comb begin
        state_next      = state_reg;
        count_next      = trxClock ? count_reg + 10'd1 : count_reg;
        bit_index_next  = bit_index_reg;
        shift_next      = shift_reg;
        byte_count_next = byte_count_reg;
        opcode_next     = opcode_reg;
        data_buf_next   = data_buf_reg;
        op_next         = op_reg;
        data_next       = data_reg;
        execute_next    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
`ifdef RECEIVER_TIMEOUT_EN
                if (timeout_hit) begin
                    byte_count_next = 3'd0;
                end
`endif
                if (!rx_s) begin
                    state_next = ST_START;
                    count_next = 10'd0;
                end
            end

            ST_START: begin
                // Confirm the start bit at its midpoint
                if (count_reg == BIT_HALF) begin
                    count_next = 10'd0;
                    if (!rx_s) begin
                        state_next     = ST_DATA;
                        bit_index_next = 3'd0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (count_reg == BIT_FULL) begin
                    count_next     = 10'd0;
                    shift_next     = {rx_s, shift_reg[7:1]};
                    bit_index_next = bit_index_reg + 3'd1;
                    if (bit_index_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                if (count_reg == BIT_FULL) begin
                    count_next = 10'd0;
                    if (rx_s) begin
                        state_next = ST_ANALYZE;
                    end else begin
                        // Framing error: abandon the byte and any partial command
                        state_next      = ST_WAITHIGH;
                        byte_count_next = 3'd0;
                    end
                end
            end

            ST_WAITHIGH: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                    count_next = 10'd0;
                end
            end

            ST_ANALYZE: begin
                state_next = ST_IDLE;
                count_next = 10'd0;
                case (byte_count_reg)
                    3'd0: begin
                        opcode_next = shift_reg;
                        if (shift_reg[LONG_CMD_BIT]) begin
                            byte_count_next = 3'd1;
                        end else begin
                            op_next      = shift_reg;
                            execute_next = 1'b1;
                        end
                    end
                    3'd1: begin
                        data_buf_next[7:0] = shift_reg;
                        byte_count_next    = 3'd2;
                    end
                    3'd2: begin
                        data_buf_next[15:8] = shift_reg;
                        byte_count_next     = 3'd3;
                    end
                    3'd3: begin
                        data_buf_next[23:16] = shift_reg;
                        byte_count_next      = 3'd4;
                    end
                    default: begin
                        // Fourth data byte completes the long command
                        op_next         = opcode_reg;
                        data_next       = {shift_reg, data_buf_reg};
                        execute_next    = 1'b1;
                        byte_count_next = 3'd0;
                    end
                endcase
            end

            default: begin
                state_next = ST_IDLE;
                count_next = 10'd0;
            end
        endcase
    end

    assign op      = op_reg;
    assign data    = data_reg;
    assign execute = execute_reg;

endmodule

// File: tb/tb_receiver.sv
// Directed testbench for the SUMP receiver with BITLENGTH=108, trxClock=1.
module tb_receiver;
    import sump_pkg::*;

    localparam int BL = 108;

    logic        clock;
    logic        reset;
    logic        trxClock;
    logic        rx;
    logic [7:0]  op;
    logic [31:0] data;
    logic        execute;

    int checks = 0;
    int errors = 0;

    int          exec_count = 0;
    logic [7:0]  cap_op     = 8'h00;
    logic [31:0] cap_data   = 32'h0;
    logic        prev_exec  = 1'b0;

    receiver #(.BITLENGTH(BL)) dut (
        .clock    (clock),
        .reset    (reset),
        .trxClock (trxClock),
        .rx       (rx),
        .op       (op),
        .data     (data),
        .execute  (execute)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every execute strobe and flag back-to-back strobes
    always @(negedge clock) begin
        if (execute) begin
            exec_count = exec_count + 1;
            cap_op     = op;
            cap_data   = data;
            checks     = checks + 1;
            if (prev_exec) begin
                errors = errors + 1;
                $display("FAIL exec_consecutive: execute high two cycles in a row (op=%02h)", op);
            end
        end
        prev_exec = execute;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BL) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BL) @(negedge clock);
        end
        rx = stop_bit;
        repeat (BL) @(negedge clock);
        rx = 1'b1;
        repeat (20) @(negedge clock);
    endtask

    task automatic expect_cmd(input string name, input int n0, input int n_exp,
                              input logic [7:0] op_exp, input logic [31:0] data_exp);
        checks++;
        if ((exec_count - n0) !== n_exp) begin
            errors++;
            $display("FAIL %s_count: got %0d executes, expected %0d", name, exec_count - n0, n_exp);
        end
        if (n_exp > 0) begin
            checks++;
            if (cap_op !== op_exp) begin
                errors++;
                $display("FAIL %s_op: got %02h, expected %02h", name, cap_op, op_exp);
            end
        end
        checks++;
        if (data !== data_exp) begin
            errors++;
            $display("FAIL %s_data: got %08h, expected %08h", name, data, data_exp);
        end
        $display("%s: executes=%0d op=%02h data=%08h", name, exec_count - n0, op, data);
    endtask

    task automatic test_reset();
        checks++;
        if (op !== 8'h00) begin errors++; $display("FAIL reset_op: got %02h, expected 00", op); end
        checks++;
        if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %08h, expected 00000000", data); end
        checks++;
        if (execute !== 1'b0) begin errors++; $display("FAIL reset_execute: got %b, expected 0", execute); end
        checks++;
        if (dut.state_reg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d, expected %0d", dut.state_reg, ST_IDLE); end
        $display("reset: op=%02h data=%08h execute=%b", op, data, execute);
    endtask

    task automatic test_short();
        int n0 = exec_count;
        send_byte(8'h02, 1'b1);
        expect_cmd("short", n0, 1, 8'h02, 32'h00000000);
    endtask

    task automatic test_long();
        int n0 = exec_count;
        send_byte(8'h80, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        checks++;
        if (exec_count != n0 || op !== 8'h02) begin
            errors++;
            $display("FAIL long_partial: executes=%0d op=%02h, expected 0 executes op=02", exec_count - n0, op);
        end
        send_byte(8'h12, 1'b1);
        expect_cmd("long", n0, 1, 8'h80, 32'h12345678);
    endtask

    task automatic test_false_start();
        int n0 = exec_count;
        rx = 1'b0;
        repeat (40) @(negedge clock);
        rx = 1'b1;
        repeat (200) @(negedge clock);
        checks++;
        if (exec_count != n0) begin errors++; $display("FAIL false_start_exec: got %0d executes, expected 0", exec_count - n0); end
        checks++;
        if (dut.state_reg !== ST_IDLE) begin errors++; $display("FAIL false_start_state: got %0d, expected %0d", dut.state_reg, ST_IDLE); end
        $display("false_start: executes=%0d", exec_count - n0);
        n0 = exec_count;
        send_byte(8'h11, 1'b1);
        expect_cmd("after_false_start", n0, 1, 8'h11, 32'h12345678);
    endtask

    task automatic test_framing();
        int n0 = exec_count;
        send_byte(8'h13, 1'b0);
        repeat (100) @(negedge clock);
        checks++;
        if (exec_count != n0) begin errors++; $display("FAIL framing_exec: got %0d executes, expected 0", exec_count - n0); end
        $display("framing: executes=%0d", exec_count - n0);
        n0 = exec_count;
        send_byte(8'h01, 1'b1);
        expect_cmd("after_framing", n0, 1, 8'h01, 32'h12345678);
    endtask

    task automatic test_reset_mid();
        int n0 = exec_count;
        send_byte(8'hC0, 1'b1);
        send_byte(8'hAA, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (op !== 8'h00) begin errors++; $display("FAIL reset_mid_op: got %02h, expected 00", op); end
        checks++;
        if (data !== 32'h0) begin errors++; $display("FAIL reset_mid_data: got %08h, expected 00000000", data); end
        checks++;
        if (exec_count != n0) begin errors++; $display("FAIL reset_mid_exec: got %0d executes, expected 0", exec_count - n0); end
        send_byte(8'h00, 1'b1);
        expect_cmd("reset_mid", n0, 1, 8'h00, 32'h00000000);
    endtask

`ifdef RECEIVER_TIMEOUT_EN
    task automatic test_timeout();
        int n0 = exec_count;
        send_byte(8'h81, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (41 * BL) @(negedge clock);
        send_byte(8'h02, 1'b1);
        expect_cmd("timeout", n0, 1, 8'h02, 32'h00000000);
    endtask
`endif

    initial begin
        trxClock = 1'b1;
        rx       = 1'b1;
        reset    = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_short();
        test_long();
        test_false_start();
        test_framing();
        test_reset_mid();
`ifdef RECEIVER_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
